if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined CPU. Owns the PC register; pc_o feeds the next-PC logic, whose result returns on npc_i.

---
 rtl/if_fetch_stage_pkg.sv | 13 +
 rtl/if_fetch_stage_if_id_reg.sv | 46 ++++
 rtl/if_fetch_stage.sv | 118 +++++++++++
 tb/tb_if_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: FSM states and the bubble instruction.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'b00,
    ST_WAIT  = 2'b01,
    ST_DROP  = 2'b10,
    ST_HOLD  = 2'b11
  } if_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register (pc, instr, valid). Priority: flush > hold > load > bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] d_pc_i,
  input  logic [31:0] d_instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // Flush and bubble keep the last pc so the slot still shows where it came from.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      if (load_i) begin
        pc_q    <= d_pc_i;
        instr_q <= d_instr_i;
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM, stall hold buffer.
// imem handshake: imem_req_o is a one-cycle strobe; exactly one imem_rvalid_i answers each request, in order.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic [1:0]  state_o
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;

  logic        ifid_load;
  logic [31:0] ifid_d_pc;
  logic [31:0] ifid_d_instr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_ISSUE;
      pc_q         <= RESET_PC;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (redirect_i) begin
            pc_q    <= npc_i;
            state_q <= ST_DROP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect_i) begin
              pc_q    <= npc_i;
              state_q <= ST_ISSUE;
            end else if (stall_i) begin
              hold_pc_q    <= pc_q;
              hold_instr_q <= imem_rdata_i;
              state_q      <= ST_HOLD;
            end else begin
              pc_q    <= npc_i;
              state_q <= ST_ISSUE;
            end
          end else if (redirect_i) begin
            pc_q    <= npc_i;
            state_q <= ST_DROP;
          end
        end
        ST_DROP: begin
          // A redirect coinciding with the stale response still leaves nothing in flight.
          if (redirect_i) pc_q <= npc_i;
          if (imem_rvalid_i) state_q <= ST_ISSUE;
        end
        ST_HOLD: begin
          if (redirect_i || !stall_i) begin
            pc_q    <= npc_i;
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_ISSUE;
      endcase
    end
  end

  // Stale responses in DROP never load: only WAIT and HOLD can deliver.
  always_comb begin
    ifid_load    = 1'b0;
    ifid_d_pc    = pc_q;
    ifid_d_instr = imem_rdata_i;
    if (state_q == ST_WAIT && imem_rvalid_i) begin
      ifid_load = 1'b1;
    end else if (state_q == ST_HOLD) begin
      ifid_load    = 1'b1;
      ifid_d_pc    = hold_pc_q;
      ifid_d_instr = hold_instr_q;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (ifid_load),
    .hold_i   (stall_i),
    .flush_i  (redirect_i),
    .d_pc_i   (ifid_d_pc),
    .d_instr_i(ifid_d_instr),
    .pc_o     (ifid_pc_o),
    .instr_o  (ifid_instr_o),
    .valid_o  (ifid_valid_o)
  );

  assign imem_req_o  = (state_q == ST_ISSUE);
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic, checked against a transaction-level model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic [31:0] npc_i;
  logic        redirect_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic [1:0]  state_o;

  if_fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .npc_i        (npc_i),
    .redirect_i   (redirect_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_valid_o (ifid_valid_o),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: fetch pc, one outstanding request (possibly stale), optional held instruction, IF/ID slot.
  logic [31:0] m_pc;
  bit          m_out, m_stale, m_held;
  logic [31:0] m_hpc, m_hinstr;
  bit          m_v;
  logic [31:0] m_ipc, m_iinstr;
  // Memory: one pending request answered after a chosen latency.
  bit          mem_pend;
  int          mem_wait;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_out = 0; m_stale = 0; m_held = 0;
    m_hpc = 0; m_hinstr = NOP;
    m_v = 0; m_ipc = 0; m_iinstr = NOP;
    mem_pend = 0; mem_wait = 0; mem_addr = 0;
  endtask

  task automatic ifid_idle(input bit stall);
    if (!stall) begin
      m_v = 0;
      m_iinstr = NOP;
    end
  endtask

  // One clock: drive inputs at negedge, compare outputs, then advance model and memory at posedge.
  task automatic step(input bit stall, input bit redir, input logic [31:0] target, input int lat);
    bit          req, rv;
    logic [31:0] npc, rdata;
    @(negedge clk);
    req   = !m_out && !m_held;
    rv    = mem_pend && (mem_wait == 0);
    rdata = rv ? mem_word(mem_addr) : $urandom;
    npc   = redir ? target : m_pc + 32'd4;
    imem_rvalid_i = rv;
    imem_rdata_i  = rdata;
    stall_i       = stall;
    redirect_i    = redir;
    npc_i         = npc;
    chk("req", {31'b0, imem_req_o}, {31'b0, req});
    chk("addr", imem_addr_o, m_pc);
    chk("pc", pc_o, m_pc);
    chk("ifid_valid", {31'b0, ifid_valid_o}, {31'b0, m_v});
    chk("ifid_pc", ifid_pc_o, m_ipc);
    chk("ifid_instr", ifid_instr_o, m_iinstr);
    @(posedge clk);
    if (rv) mem_pend = 0;
    else if (mem_pend) mem_wait--;
    if (req) begin
      mem_pend = 1;
      mem_wait = lat - 1;
      mem_addr = m_pc;
    end
    if (redir) begin
      m_v = 0; m_iinstr = NOP; m_held = 0;
      if (req) begin m_out = 1; m_stale = 1; end
      else if (m_out && rv) m_out = 0;
      else if (m_out) m_stale = 1;
      m_pc = npc;
    end else if (req) begin
      m_out = 1; m_stale = 0;
      ifid_idle(stall);
    end else if (m_out && rv) begin
      m_out = 0;
      if (m_stale) ifid_idle(stall);
      else if (stall) begin
        m_held = 1; m_hpc = m_pc; m_hinstr = rdata;
      end else begin
        m_v = 1; m_ipc = m_pc; m_iinstr = rdata; m_pc = npc;
      end
    end else if (m_held) begin
      if (!stall) begin
        m_v = 1; m_ipc = m_hpc; m_iinstr = m_hinstr; m_held = 0; m_pc = npc;
      end
    end else begin
      ifid_idle(stall);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc_o, RST_PC);
    chk({tag, "_req"}, {31'b0, imem_req_o}, 32'd1);
    chk({tag, "_valid"}, {31'b0, ifid_valid_o}, 32'd0);
    chk({tag, "_ifid_pc"}, ifid_pc_o, 32'h0);
    chk({tag, "_instr"}, ifid_instr_o, NOP);
  endtask

  initial begin
    rstn = 1'b1; npc_i = 0; redirect_i = 0; stall_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    model_reset();
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rstn = 1'b1;

    // 1: latency 1, no stall: fetch 0x0 and 0x4
    repeat (4) step(0, 0, 0, 1);
    #1 chk("t1_ifid_pc", ifid_pc_o, 32'h4);
    chk("t1_valid", {31'b0, ifid_valid_o}, 32'd1);
    // 2: stall as 0x8 arrives, two stall cycles, then release
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    #1 chk("t2_state_hold", {30'b0, state_o}, 32'd3);
    chk("t2_ifid_held", ifid_pc_o, 32'h4);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    #1 chk("t2_ifid_pc", ifid_pc_o, 32'h8);
    chk("t2_pc", pc_o, 32'hC);
    // 3: redirect to 0x100 while waiting on 0x10 with latency 3
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 3);
    step(0, 1, 32'h100, 1);
    #1 chk("t3_state_drop", {30'b0, state_o}, 32'd2);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    #1 chk("t3_addr", imem_addr_o, 32'h100);
    chk("t3_valid", {31'b0, ifid_valid_o}, 32'd0);
    // 4: redirect at issue, then redirect together with rvalid for 0x20
    step(0, 1, 32'h20, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h40, 1);
    #1 chk("t4_addr", imem_addr_o, 32'h40);
    chk("t4_instr", ifid_instr_o, NOP);
    // 5: redirect and stall together in HOLD
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 1, 32'h80, 1);
    #1 chk("t5_pc", pc_o, 32'h80);
    chk("t5_state_issue", {30'b0, state_o}, 32'd0);
    // 6: reset while waiting on 0x80
    step(0, 0, 0, 3);
    step(0, 0, 0, 3);
    @(negedge clk);
    redirect_i = 0; stall_i = 0; imem_rvalid_i = 0;
    rstn = 1'b0;
    #1 check_reset_outputs("t6");
    model_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
    // PC wrap at 2^32
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFC, 1);
    repeat (5) step(0, 0, 0, 1);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom & 32'hFFFF_FFFC, $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
